// File: rtl/data_memory_lsu.sv
// data_memory_lsu: byte-addressable word memory with a load/store unit that answers every accepted request one cycle later.
// Define DATA_MEMORY_LSU_CLEAR_EN to zero the whole array with a sweep after each reset.
module data_memory_lsu #(
    parameter int ADDRSIZE = 5,
    parameter int WORDSIZE = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    input  logic [ADDRSIZE+1:0] address,
    input  logic [WORDSIZE-1:0] writeData,
    output logic [WORDSIZE-1:0] readData,
    output logic                rsp_valid,
    output logic                rsp_error
);
    localparam int MEMSIZE = 1 << ADDRSIZE;

    logic [WORDSIZE-1:0] mem [MEMSIZE];

    logic                accept;
    logic                illegal;
    logic                st_we;
    logic [ADDRSIZE-1:0] widx;
    logic [WORDSIZE-1:0] word_rd;

    logic                vld_p1;
    logic                err_p1;
    logic [WORDSIZE-1:0] rdata_p1;

    // Pull the addressed byte/half out of a word and extend it to 32 bits.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  size,
                                                 input logic [1:0]  lane,
                                                 input logic        uns);
        logic [31:0] sh;
        logic [31:0] res;
        sh = word >> {lane, 3'b000};
        case (size)
            2'b00:   res = uns ? {24'h000000, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            2'b01:   res = uns ? {16'h0000, sh[15:0]}   : {{16{sh[15]}}, sh[15:0]};
            default: res = word;
        endcase
        return res;
    endfunction

    // Replace only the addressed byte lanes of the old word with right-aligned store data.
    function automatic logic [31:0] lane_merge(input logic [31:0] old,
                                               input logic [31:0] wd,
                                               input logic [1:0]  size,
                                               input logic [1:0]  lane);
        logic [31:0] mask;
        logic [31:0] sh;
        sh = wd << {lane, 3'b000};
        case (size)
            2'b00:   mask = 32'h0000_00FF << {lane, 3'b000};
            2'b01:   mask = 32'h0000_FFFF << {lane, 3'b000};
            default: mask = 32'hFFFF_FFFF;
        endcase
        return (old & ~mask) | (sh & mask);
    endfunction

    function automatic logic is_illegal(input logic [1:0] size, input logic [1:0] lane);
        logic bad;
        case (size)
            2'b00:   bad = 1'b0;
            2'b01:   bad = lane[0];
            2'b10:   bad = (lane != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    assign widx    = address[ADDRSIZE+1:2];
    assign word_rd = mem[widx];
    assign accept  = req_valid && req_ready;
    assign illegal = is_illegal(req_size, address[1:0]);
    assign st_we   = accept && req_write && !illegal;

`ifdef DATA_MEMORY_LSU_CLEAR_EN
    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ADDRSIZE-1:0] cnt;
    logic [ADDRSIZE-1:0] cnt_nxt;
    logic                clr_we;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // The sweep writes one word per cycle and hands over to IDLE after the last index.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        req_ready = 1'b0;
        clr_we    = 1'b0;
        case (state)
            CLEAR: begin
                clr_we  = 1'b1;
                cnt_nxt = cnt + ADDRSIZE'(1);
                if (cnt == ADDRSIZE'(MEMSIZE - 1))
                    state_nxt = IDLE;
            end
            IDLE: begin
                req_ready = 1'b1;
            end
            default: begin
                state_nxt = CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr_we)
            mem[cnt] <= '0;
        else if (st_we)
            mem[widx] <= lane_merge(word_rd, writeData, req_size, address[1:0]);
    end
`else
    // Without the sweep the block is ready whenever it is out of reset.
    assign req_ready = reset_n;

    always_ff @(posedge clk) begin
        if (st_we)
            mem[widx] <= lane_merge(word_rd, writeData, req_size, address[1:0]);
    end
`endif

    // Stage p1: response registered at the accepting edge; data holds when nothing is accepted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1   <= 1'b0;
            err_p1   <= 1'b0;
            rdata_p1 <= '0;
        end else if (accept) begin
            vld_p1   <= 1'b1;
            err_p1   <= illegal;
            rdata_p1 <= (illegal || req_write) ? '0
                        : load_extract(word_rd, req_size, address[1:0], req_unsigned);
        end else begin
            vld_p1   <= 1'b0;
            err_p1   <= 1'b0;
        end
    end

    assign readData  = rdata_p1;
    assign rsp_valid = vld_p1;
    assign rsp_error = err_p1;

endmodule

// File: doc/data_memory_lsu.md
DATA_MEMORY_LSU -- requirements
Module: data_memory_lsu

Interface
REQ-001 SHALL have parameter ADDRSIZE, default 5, meaning log2 of word count (MEMSIZE = 2^ADDRSIZE words).
REQ-002 SHALL have parameter WORDSIZE, default 32, meaning word width in bits; only 32 is legal.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port req_valid, input, 1, request present.
REQ-006 SHALL have port req_ready, output, 1, block can accept a request this cycle.
REQ-007 SHALL have port req_write, input, 1: 1 = store, 0 = load.
REQ-008 SHALL have port req_size, input, 2: 00 byte, 01 half, 10 word, 11 illegal.
REQ-009 SHALL have port req_unsigned, input, 1: zero-extend (1) or sign-extend (0) sub-word loads.
REQ-010 SHALL have port address, input, ADDRSIZE+2, byte address.
REQ-011 SHALL have port writeData, input, 32, store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-012 SHALL have port readData, output, 32, registered load result.
REQ-013 SHALL have port rsp_valid, output, 1, one-cycle response pulse.
REQ-014 SHALL have port rsp_error, output, 1, qualifies rsp_valid; misaligned or illegal request.

Function
REQ-015 Request SHALL be accepted on a rising edge where req_valid && req_ready.
REQ-016 Every accepted request SHALL produce exactly one rsp_valid pulse on the following cycle (latency 1); back-to-back acceptance every cycle SHALL be supported.
REQ-017 Store SHALL write only the addressed byte lanes (byte: lane address[1:0]; half: lanes address[1]*2..+1; word: all four) at the accepting edge; other lanes unchanged.
REQ-018 Load SHALL extract the addressed lane(s) and extend per req_unsigned into readData; word loads ignore req_unsigned.
REQ-019 Store response SHALL set readData to 0.
REQ-020 Misaligned (half with address[0]=1; word with address[1:0]!=0) or req_size=11 SHALL not modify memory and SHALL return rsp_error=1, readData=0.
REQ-021 rsp_error SHALL be 0 for legal requests; rsp_valid, rsp_error SHALL be 0 in cycles with no response.
REQ-022 readData SHALL hold its last value when rsp_valid is 0.
REQ-023 Load accepted the cycle after a store to the same word SHALL return the post-store data.
REQ-024 FSM states: CLEAR (req_ready=0, writes zero to word index cnt, cnt increments each cycle) and IDLE (req_ready=1).
REQ-025 CLEAR -> IDLE after writing index MEMSIZE-1; IDLE has no exit except reset.
REQ-026 req_valid during CLEAR SHALL be ignored (no acceptance, no response).

Reset
REQ-027 While reset_n=0: readData=0, rsp_valid=0, rsp_error=0, cnt=0, state=CLEAR (if clear enabled) else IDLE.
REQ-028 Reset asserted mid-CLEAR SHALL restart the sweep from index 0 after release.
REQ-029 Reset asserted in the cycle after acceptance SHALL suppress that response.
REQ-030 With clear enabled, req_ready SHALL first be 1 exactly MEMSIZE rising edges after reset_n release.

Configuration
REQ-031 Macro DATA_MEMORY_LSU_CLEAR_EN SHALL select the post-reset sweep.
REQ-032 Defined: reset enters CLEAR as in REQ-024/025/030; all words read 0 afterwards.
REQ-033 Undefined: no CLEAR state or cnt logic; reset enters IDLE, req_ready=1 immediately after reset; memory contents not altered by reset.

Verification
REQ-034 CLEAR_EN, ADDRSIZE=5: release reset -> req_ready 0 for 32 cycles, 1 on the 32nd edge; word load any address -> 0x00000000, rsp_error=0.
REQ-035 Store word 0xDEADBEEF @0x08, then LB @0x0B, LBU @0x0B, LH @0x0A, LHU @0x08 -> 0xFFFFFFDE, 0x000000DE, 0xFFFFDEAD, 0x0000BEEF.
REQ-036 Store byte 0x55 @0x09 over 0xDEADBEEF, then word load @0x08 -> 0xDEAD55EF.
REQ-037 Word store @0x06, half load @0x03, req_size=11 @0x00 -> each rsp_valid=1, rsp_error=1, readData=0; memory at 0x04 unchanged.
REQ-038 Store 0x12345678 @0x10 cycle N, load @0x10 cycle N+1 -> readData 0x12345678 at N+2; rsp_valid high at N+1 and N+2.
REQ-039 Reset pulse at sweep index 10 -> after release req_ready stays 0 for 32 more cycles; without CLEAR_EN, data stored before reset reads back unchanged.
